// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed FIR sequencer:
//   - default width / tap-count localparams used as parameter defaults
//   - sequencer state enum (IDLE -> MAC -> DONE)
//   - signed sample and coefficient typedefs for the default widths
//   - fir_acc_w(): accumulator width that cannot overflow for a given config
// No ports (package).
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_N         = 24;
    localparam int FIR_N_COEFF   = 16;
    localparam int FIR_N_TAPS    = 61;
    localparam int FIR_OUT_SHIFT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    typedef logic signed [FIR_N-1:0]       sample_t;
    typedef logic signed [FIR_N_COEFF-1:0] coef_t;

    // Full product width plus enough guard bits to sum n_taps products.
    function automatic int fir_acc_w(input int n, input int n_coeff, input int n_taps);
        return n + n_coeff + $clog2(n_taps);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// -----------------------------------------------------------------------------
// fir_mac
// Registered signed multiply-accumulate shared by all taps of the FIR.
//   clk      in   clock
//   reset_n  in   synchronous active-low reset (clears the accumulator)
//   clr      in   load zero into the accumulator (has priority over en)
//   en       in   accumulate a*b this cycle
//   a        in   signed A_W-bit operand (sample)
//   b        in   signed B_W-bit operand (coefficient)
//   acc      out  signed ACC_W-bit accumulator
// -----------------------------------------------------------------------------
module fir_mac #(
    parameter int A_W   = 24,
    parameter int B_W   = 16,
    parameter int ACC_W = 46
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PW  = A_W + B_W;
    localparam int EXT = ACC_W - PW;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Full-width signed product, sign-extended into the accumulator width.
    always_comb begin
        prod  = PW'(a) * PW'(b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{EXT{prod[PW-1]}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_mac_sched.sv
// -----------------------------------------------------------------------------
// fir_mac_sched
// Time-multiplexed FIR: one shared MAC walks all N_TAPS taps per accepted
// sample (N_TAPS+2 cycles per sample), using a circular sample history and a
// writable coefficient bank.
//   clk           in   clock
//   reset_n       in   synchronous active-low reset
//   sample_in     in   signed input sample (N bits)
//   sample_valid  in   sample_in is valid
//   sample_ready  out  block accepts a sample (IDLE only)
//   coef_wr_en    in   coefficient write strobe
//   coef_addr     in   tap index to write
//   coef_data     in   signed Q1.15 coefficient
//   coef_wr_err   out  one-cycle pulse: previous write was rejected
//   data_out      out  signed filtered sample, held until the next result
//   out_valid     out  one-cycle pulse: data_out updated
//   busy          out  high in MAC or DONE
// Build option: define FIR_SAT_EN to clamp the output to the N-bit signed
// range instead of wrapping.
// -----------------------------------------------------------------------------
module fir_mac_sched
    import fir_pkg::*;
#(
    parameter int N         = FIR_N,
    parameter int N_COEFF   = FIR_N_COEFF,
    parameter int N_TAPS    = FIR_N_TAPS,
    parameter int OUT_SHIFT = FIR_OUT_SHIFT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic signed [N-1:0]       sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      coef_wr_en,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr,
    input  logic signed [N_COEFF-1:0] coef_data,
    output logic                      coef_wr_err,
    output logic signed [N-1:0]       data_out,
    output logic                      out_valid,
    output logic                      busy
);

    localparam int            AW       = $clog2(N_TAPS);
    localparam int            ACC_W    = fir_acc_w(N, N_COEFF, N_TAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);

    fir_state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] k_q, k_d;
    logic signed [N-1:0]       hist_q [N_TAPS];
    logic signed [N-1:0]       hist_d [N_TAPS];
    logic signed [N_COEFF-1:0] coef_q [N_TAPS];
    logic signed [N_COEFF-1:0] coef_d [N_TAPS];
    logic signed [N-1:0] data_out_q, data_out_d;
    logic out_valid_q, out_valid_d;
    logic coef_wr_err_q, coef_wr_err_d;

    logic                    mac_clr;
    logic                    mac_en;
    logic [AW:0]             idx_diff;
    logic [AW-1:0]           hist_idx;
    logic                    addr_ok;
    logic signed [ACC_W-1:0] acc;
    logic signed [N-1:0]     acc_out;
    logic                    acc_unused;
`ifdef FIR_SAT_EN
    logic [ACC_W-OUT_SHIFT-N:0] acc_hi;
`endif

    // History slot for tap k is (wr_ptr - k) mod N_TAPS; a borrow out of the
    // subtraction is corrected by adding N_TAPS back, so no divider is needed.
    always_comb begin
        idx_diff = {1'b0, wr_ptr_q} - {1'b0, k_q};
        if (idx_diff[AW]) begin
            hist_idx = AW'(idx_diff + (AW+1)'(N_TAPS));
        end else begin
            hist_idx = idx_diff[AW-1:0];
        end
        addr_ok = ({1'b0, coef_addr} < (AW+1)'(N_TAPS));
    end

    fir_mac #(
        .A_W  (N),
        .B_W  (N_COEFF),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      (hist_q[hist_idx]),
        .b      (coef_q[k_q]),
        .acc    (acc)
    );

    // Output scaling: take N bits starting at OUT_SHIFT (floor). With
    // saturation enabled, any disagreement among the bits above the kept sign
    // bit means the value is out of range and is clamped by the acc sign.
    always_comb begin
        acc_out = acc[OUT_SHIFT+N-1:OUT_SHIFT];
`ifdef FIR_SAT_EN
        acc_hi = acc[ACC_W-1:OUT_SHIFT+N-1];
        if (!(&acc_hi) && (|acc_hi)) begin
            acc_out = acc[ACC_W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    assign acc_unused = ^{acc[ACC_W-1:OUT_SHIFT+N], acc[OUT_SHIFT-1:0]};

    // Sequencer. A coefficient write in the same IDLE cycle as an accepted
    // sample lands in the bank at the same edge, before the first MAC reads it.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        k_d           = k_q;
        hist_d        = hist_q;
        coef_d        = coef_q;
        data_out_d    = data_out_q;
        out_valid_d   = 1'b0;
        coef_wr_err_d = 1'b0;
        mac_clr       = 1'b0;
        mac_en        = 1'b0;

        if (coef_wr_en) begin
            if (state_q == ST_IDLE && addr_ok) begin
                coef_d[coef_addr] = coef_data;
            end else begin
                coef_wr_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    hist_d[wr_ptr_q] = sample_in;
                    mac_clr          = 1'b1;
                    k_d              = '0;
                    state_d          = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k_q == LAST_TAP) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            ST_DONE: begin
                data_out_d  = acc_out;
                out_valid_d = 1'b1;
                wr_ptr_d    = (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + AW'(1);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            k_q           <= '0;
            hist_q        <= '{default: '0};
            coef_q        <= '{default: '0};
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            coef_wr_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            k_q           <= k_d;
            hist_q        <= hist_d;
            coef_q        <= coef_d;
            data_out_q    <= data_out_d;
            out_valid_q   <= out_valid_d;
            coef_wr_err_q <= coef_wr_err_d;
        end
    end

    assign sample_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign data_out     = data_out_q;
    assign out_valid    = out_valid_q;
    assign coef_wr_err  = coef_wr_err_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sched
// Two instances: a 4-tap filter for the directed scenarios and a default
// 61-tap filter for a long random stream. Expected outputs come from a
// sum-of-products reference over a newest-first sample list and are queued
// at acceptance; per-instance monitors pop and compare on out_valid.
// -----------------------------------------------------------------------------
module tb_fir_mac_sched;

    localparam int S_TAPS    = 4;
    localparam int B_TAPS    = 61;
    localparam int OUT_SHIFT = 15;
    localparam int B_SAMPLES = 700;

    typedef struct {
        logic [23:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // 4-tap instance signals
    logic        s_reset_n = 1'b0;
    logic [23:0] s_sample_in = '0;
    logic        s_sample_valid = 1'b0;
    logic        s_sample_ready;
    logic        s_coef_wr_en = 1'b0;
    logic [1:0]  s_coef_addr = '0;
    logic [15:0] s_coef_data = '0;
    logic        s_coef_wr_err;
    logic [23:0] s_data_out;
    logic        s_out_valid;
    logic        s_busy;

    // 61-tap instance signals
    logic        b_reset_n = 1'b0;
    logic [23:0] b_sample_in = '0;
    logic        b_sample_valid = 1'b0;
    logic        b_sample_ready;
    logic        b_coef_wr_en = 1'b0;
    logic [5:0]  b_coef_addr = '0;
    logic [15:0] b_coef_data = '0;
    logic        b_coef_wr_err;
    logic [23:0] b_data_out;
    logic        b_out_valid;
    logic        b_busy;

    // Reference model state: newest sample first, coefficients by tap index.
    longint s_hist[$];
    longint s_coef[$];
    longint b_hist[$];
    longint b_coef[$];
    exp_t   s_exp[$];
    exp_t   b_exp[$];

    fir_mac_sched #(
        .N(24), .N_COEFF(16), .N_TAPS(S_TAPS), .OUT_SHIFT(OUT_SHIFT)
    ) dut_s (
        .clk(clk), .reset_n(s_reset_n),
        .sample_in(s_sample_in), .sample_valid(s_sample_valid), .sample_ready(s_sample_ready),
        .coef_wr_en(s_coef_wr_en), .coef_addr(s_coef_addr), .coef_data(s_coef_data),
        .coef_wr_err(s_coef_wr_err), .data_out(s_data_out), .out_valid(s_out_valid),
        .busy(s_busy)
    );

    fir_mac_sched dut_b (
        .clk(clk), .reset_n(b_reset_n),
        .sample_in(b_sample_in), .sample_valid(b_sample_valid), .sample_ready(b_sample_ready),
        .coef_wr_en(b_coef_wr_en), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
        .coef_wr_err(b_coef_wr_err), .data_out(b_data_out), .out_valid(b_out_valid),
        .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // y[n] = floor(sum_k c[k]*x[n-k] / 2^OUT_SHIFT), then clamp or wrap to 24 bits.
    function automatic logic [23:0] firRef(input longint hist[$], input longint coefs[$]);
        longint acc = 0;
        longint sh;
        for (int k = 0; k < coefs.size(); k++) begin
            if (k < hist.size()) acc += coefs[k] * hist[k];
        end
        sh = acc >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        if (sh > 64'sd8388607) sh = 64'sd8388607;
        else if (sh < -64'sd8388608) sh = -64'sd8388608;
`endif
        return sh[23:0];
    endfunction

    task automatic modelAcceptSmall(input logic [23:0] smp);
        exp_t e;
        s_hist.push_front(longint'($signed(smp)));
        if (s_hist.size() > S_TAPS) void'(s_hist.pop_back());
        e.data = firRef(s_hist, s_coef);
        e.cyc  = cyc + S_TAPS + 2;
        s_exp.push_back(e);
    endtask

    task automatic modelAcceptBig(input logic [23:0] smp);
        exp_t e;
        b_hist.push_front(longint'($signed(smp)));
        if (b_hist.size() > B_TAPS) void'(b_hist.pop_back());
        e.data = firRef(b_hist, b_coef);
        e.cyc  = cyc + B_TAPS + 2;
        b_exp.push_back(e);
    endtask

    // Scoreboard monitors: every out_valid must match the oldest expectation,
    // both in value and in the cycle it was due.
    always @(negedge clk) begin
        if (s_out_valid === 1'b1) begin
            if (s_exp.size() == 0) begin
                checkOutput("s_unexpected_out_valid", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = s_exp.pop_front();
                checkOutput("s_data_out", 64'(s_data_out), 64'(e.data));
                checkOutput("s_out_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid === 1'b1) begin
            if (b_exp.size() == 0) begin
                checkOutput("b_unexpected_out_valid", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = b_exp.pop_front();
                checkOutput("b_data_out", 64'(b_data_out), 64'(e.data));
                checkOutput("b_out_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic waitReadySmall();
        int waited = 0;
        @(negedge clk);
        while (s_sample_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) checkOutput("s_ready_timeout", 64'(waited), 64'(0));
    endtask

    // Offer one sample to the 4-tap instance, optionally with a coefficient
    // write in the same IDLE cycle.
    task automatic applyStimulus(input logic [23:0] smp, input bit withCoef,
                                 input int addr, input logic [15:0] cval);
        waitReadySmall();
        if (withCoef) begin
            s_coef_wr_en = 1'b1;
            s_coef_addr  = 2'(addr);
            s_coef_data  = cval;
            s_coef[addr] = longint'($signed(cval));
        end
        s_sample_in    = smp;
        s_sample_valid = 1'b1;
        modelAcceptSmall(smp);
        @(negedge clk);
        s_sample_valid = 1'b0;
        s_coef_wr_en   = 1'b0;
        if (withCoef) checkOutput("s_coef_wr_err_with_sample", 64'(s_coef_wr_err), 64'(0));
    endtask

    task automatic writeCoefSmall(input int addr, input logic [15:0] val, input logic expErr);
        if (!expErr) waitReadySmall();
        else @(negedge clk);
        s_coef_wr_en = 1'b1;
        s_coef_addr  = 2'(addr);
        s_coef_data  = val;
        if (!expErr) s_coef[addr] = longint'($signed(val));
        @(negedge clk);
        s_coef_wr_en = 1'b0;
        checkOutput("s_coef_wr_err", 64'(s_coef_wr_err), 64'(expErr));
    endtask

    task automatic applyStimulusBig(input logic [23:0] smp);
        int waited = 0;
        @(negedge clk);
        while (b_sample_ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) begin
            checkOutput("b_ready_timeout", 64'(waited), 64'(0));
            return;
        end
        b_sample_in    = smp;
        b_sample_valid = 1'b1;
        modelAcceptBig(smp);
        @(negedge clk);
        b_sample_valid = 1'b0;
    endtask

    task automatic writeCoefBig(input int addr, input logic [15:0] val, input logic expErr);
        @(negedge clk);
        b_coef_wr_en = 1'b1;
        b_coef_addr  = 6'(addr);
        b_coef_data  = val;
        if (!expErr) b_coef[addr] = longint'($signed(val));
        @(negedge clk);
        b_coef_wr_en = 1'b0;
        checkOutput("b_coef_wr_err", 64'(b_coef_wr_err), 64'(expErr));
    endtask

    task automatic loadImpulseCoefs();
        writeCoefSmall(0, 16'h4000, 1'b0);
        writeCoefSmall(1, 16'h2000, 1'b0);
        writeCoefSmall(2, 16'h1000, 1'b0);
        writeCoefSmall(3, 16'h0800, 1'b0);
    endtask

    task automatic runSmallTests();
        int prevAcc = -1;

        // Impulse response through the four taps.
        loadImpulseCoefs();
        applyStimulus(24'h100000, 1'b0, 0, 16'h0);
        repeat (4) applyStimulus(24'h000000, 1'b0, 0, 16'h0);

        // Handshake: valid held high, only IDLE cycles accept.
        waitReadySmall();
        for (int c = 0; c < 30; c++) begin
            if (c != 0) @(negedge clk);
            s_sample_in    = 24'($urandom);
            s_sample_valid = 1'b1;
            if (s_sample_ready === 1'b1) begin
                if (prevAcc >= 0) checkOutput("s_accept_interval", 64'(cyc - prevAcc), 64'(S_TAPS + 2));
                prevAcc = cyc;
                modelAcceptSmall(s_sample_in);
            end
        end
        @(negedge clk);
        s_sample_valid = 1'b0;

        // Coefficient write while busy is rejected and leaves the bank alone.
        applyStimulus(24'h0A0000, 1'b0, 0, 16'h0);
        writeCoefSmall(0, 16'h7FFF, 1'b1);
        applyStimulus(24'h050000, 1'b0, 0, 16'h0);

        // Coefficient write together with a sample is used by that sample.
        applyStimulus(24'h040000, 1'b1, 1, 16'h7000);
        applyStimulus(24'hF30000, 1'b0, 0, 16'h0);

        // Large coefficients and samples: saturation or wrap-around.
        for (int a = 0; a < S_TAPS; a++) writeCoefSmall(a, 16'h7FFF, 1'b0);
        repeat (4) applyStimulus(24'h7FFFFF, 1'b0, 0, 16'h0);
        applyStimulus(24'h800000, 1'b0, 0, 16'h0);

        // Reset two cycles into MAC aborts the computation.
        applyStimulus(24'h123456, 1'b0, 0, 16'h0);
        @(negedge clk);
        s_reset_n = 1'b0;
        @(negedge clk);
        s_reset_n = 1'b1;
        s_exp.delete();
        s_hist.delete();
        for (int a = 0; a < S_TAPS; a++) s_coef[a] = 0;
        checkOutput("s_reset_data_out", 64'(s_data_out), 64'(0));
        checkOutput("s_reset_out_valid", 64'(s_out_valid), 64'(0));
        checkOutput("s_reset_busy", 64'(s_busy), 64'(0));
        checkOutput("s_reset_ready", 64'(s_sample_ready), 64'(1));
        repeat (S_TAPS + 4) @(negedge clk);
        loadImpulseCoefs();
        applyStimulus(24'h100000, 1'b0, 0, 16'h0);
        repeat (4) applyStimulus(24'h000000, 1'b0, 0, 16'h0);
    endtask

    task automatic runBigTests();
        int v;
        // Symmetric (linear-phase) coefficient set.
        for (int k = 0; k < B_TAPS; k++) b_coef.push_back(0);
        for (int k = 0; k <= B_TAPS / 2; k++) begin
            v = int'($urandom_range(0, 4095)) - 2048;
            writeCoefBig(k, 16'(v), 1'b0);
            if (k != B_TAPS - 1 - k) writeCoefBig(B_TAPS - 1 - k, 16'(v), 1'b0);
        end
        // Out-of-range tap indices are rejected.
        writeCoefBig(61, 16'h1234, 1'b1);
        writeCoefBig(63, 16'h4321, 1'b1);
        for (int i = 0; i < B_SAMPLES; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulusBig(24'($urandom));
        end
    endtask

    initial begin
        for (int k = 0; k < S_TAPS; k++) s_coef.push_back(0);
        repeat (3) @(negedge clk);
        s_reset_n = 1'b1;
        b_reset_n = 1'b1;
        @(negedge clk);
        checkOutput("s_init_data_out", 64'(s_data_out), 64'(0));
        checkOutput("s_init_out_valid", 64'(s_out_valid), 64'(0));
        checkOutput("s_init_busy", 64'(s_busy), 64'(0));
        checkOutput("s_init_ready", 64'(s_sample_ready), 64'(1));
        checkOutput("s_init_wr_err", 64'(s_coef_wr_err), 64'(0));
        checkOutput("b_init_data_out", 64'(b_data_out), 64'(0));
        checkOutput("b_init_ready", 64'(b_sample_ready), 64'(1));

        fork
            runSmallTests();
            runBigTests();
        join

        for (int w = 0; w < 500 && (s_exp.size() != 0 || b_exp.size() != 0); w++) @(negedge clk);
        checkOutput("drain_pending", 64'(s_exp.size() + b_exp.size()), 64'(0));
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
